rv32i_multicycle_ctrl: RTL

Multi-cycle control FSM that sequences the RV32I datapath: instruction fetch, decode, execute, memory and writeback. It drives the immediate-type select for the immediate generator (I/S/B/U/J) plus PC, IR, ALU-source, register-file and data-memory strobes. It talks to instruction and data memory over simple req/valid and req/ack handshakes, so memories with variable latency are supported. It also keeps a retired-instruction counter and a sticky illegal-instruction trap.

---
 rtl/rv32i_multicycle_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over variable-latency memory handshakes and keeps instret plus a sticky trap.
module rv32i_multicycle_ctrl #(
   parameter int RESET_WAIT = 0,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             imem_valid,
   input  logic             dmem_ack,
   input  logic             br_taken,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [2:0]       imm_sel,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_IMM   = 2'd1;
   localparam logic [1:0] PC_ALU   = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;
   localparam logic [1:0] WB_IMM  = 2'd3;

   localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_I,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WAIT_D,
      S_WB,
      S_TRAP
   } state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic             trap_q;
   logic [CNT_W-1:0] instret_q;

   logic [6:0] opcode;
   logic       is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic       is_load, is_store, is_opimm, is_op, legal;
   logic [2:0] imm_dec;
   logic [1:0] wb_dec;
   logic       src_a_dec, src_b_dec;

   // Upper instruction bits (funct/register fields) are consumed by the datapath only.
   logic unused_inst;
   assign unused_inst = ^inst[31:7];

   assign opcode    = inst[6:0];
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_opimm  = (opcode == OP_OPIMM);
   assign is_op     = (opcode == OP_OP);
   assign legal     = (inst[1:0] == 2'b11) &&
                      (is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                       is_load || is_store || is_opimm || is_op);

   always_comb begin
      imm_dec = IMM_I;
      case (opcode)
         OP_STORE:         imm_dec = IMM_S;
         OP_BRANCH:        imm_dec = IMM_B;
         OP_LUI, OP_AUIPC: imm_dec = IMM_U;
         OP_JAL:           imm_dec = IMM_J;
         default:          imm_dec = IMM_I;
      endcase
   end

   always_comb begin
      wb_dec = WB_ALU;
      if (is_lui)
         wb_dec = WB_IMM;
      else if (is_load)
         wb_dec = WB_LOAD;
      else if (is_jal || is_jalr)
         wb_dec = WB_PC4;
   end

   // PC feeds operand A for AUIPC and the JAL link; only OP and BRANCH compare two registers.
   assign src_a_dec = is_auipc || is_jal;
   assign src_b_dec = !(is_op || is_branch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= 4'd0;
         trap_q    <= 1'b0;
         instret_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wait_cnt == WAIT_LAST)
                  state <= S_FETCH;
               else
                  wait_cnt <= wait_cnt + 4'd1;
            end
            S_FETCH:  state <= S_WAIT_I;
            S_WAIT_I: if (imem_valid) state <= S_DECODE;
            S_DECODE: begin
               if (legal) begin
                  state <= S_EXEC;
               end else begin
                  state  <= S_TRAP;
                  trap_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_load || is_store) begin
                  state <= S_MEM;
               end else if (is_branch) begin
                  state     <= S_FETCH;
                  instret_q <= instret_q + CNT_W'(1);
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: state <= S_WAIT_D;
            S_WAIT_D: begin
               if (dmem_ack) begin
                  if (is_store) begin
                     state     <= S_FETCH;
                     instret_q <= instret_q + CNT_W'(1);
                  end else begin
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               state     <= S_FETCH;
               instret_q <= instret_q + CNT_W'(1);
            end
            S_TRAP:  state <= S_TRAP;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode straight from the state register so handshake responses land in the same cycle.
   always_comb begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PC_PLUS4;
      imm_sel   = IMM_I;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = WB_ALU;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH:  imem_req = 1'b1;
            S_WAIT_I: ir_we = imem_valid;
            S_DECODE: imm_sel = imm_dec;
            S_EXEC: begin
               imm_sel   = imm_dec;
               alu_src_a = src_a_dec;
               alu_src_b = src_b_dec;
               if (is_branch) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? PC_IMM : PC_PLUS4;
               end else if (is_jal) begin
                  pc_we  = 1'b1;
                  pc_sel = PC_IMM;
               end else if (is_jalr) begin
                  pc_we  = 1'b1;
                  pc_sel = PC_ALU;
               end
            end
            S_MEM: begin
               imm_sel   = imm_dec;
               alu_src_a = src_a_dec;
               alu_src_b = src_b_dec;
               dmem_req  = 1'b1;
               dmem_we   = is_store;
            end
            S_WAIT_D: begin
               imm_sel   = imm_dec;
               alu_src_a = src_a_dec;
               alu_src_b = src_b_dec;
               pc_we     = dmem_ack && is_store;
            end
            S_WB: begin
               imm_sel   = imm_dec;
               alu_src_a = src_a_dec;
               alu_src_b = src_b_dec;
               rf_we     = 1'b1;
               wb_sel    = wb_dec;
               pc_we     = !(is_jal || is_jalr);
            end
            default: ;
         endcase
      end
   end

   assign trap    = trap_q && !rst;
   assign instret = rst ? '0 : instret_q;

endmodule
